// File: rtl/tf_call_pkg.sv
// Shared types and constants for the task/function call responder.
//   fid_e    : routine selector (SUM, DOUBLE, NO_ARGS, TASK1)
//   kind_e   : call context of the initiator
//   status_e : response status code
//   ARITY    : expected argument count per routine
//   is_task  : true for routines with task (statement-only) semantics
package tf_call_pkg;

  typedef enum logic [1:0] {
    FID_SUM     = 2'd0,
    FID_DOUBLE  = 2'd1,
    FID_NO_ARGS = 2'd2,
    FID_TASK1   = 2'd3
  } fid_e;

  typedef enum logic [1:0] {
    KIND_EXPR      = 2'd0,
    KIND_STMT      = 2'd1,
    KIND_VOID_CAST = 2'd2,
    KIND_RSVD      = 2'd3
  } kind_e;

  typedef enum logic [1:0] {
    ST_OK        = 2'd0,
    ST_ERR_ARITY = 2'd1,
    ST_ERR_CTX   = 2'd2
  } status_e;

  // Indexed by fid: SUM, DOUBLE, NO_ARGS, TASK1.
  localparam logic [1:0] ARITY [4] = '{2'd2, 2'd1, 2'd0, 2'd1};

  function automatic logic is_task(input fid_e fid);
    return fid == FID_TASK1;
  endfunction

endpackage

// File: rtl/tf_call_exec.sv
// Combinational executor: arity/context checks and routine result.
//   fid_i, kind_i, nargs_i : latched call descriptor
//   a0_i, a1_i             : first two argument slots
//   result_o               : routine result (0 on error or discard)
//   status_o               : OK / ERR_ARITY / ERR_CTX
module tf_call_exec
  import tf_call_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  fid_e              fid_i,
  input  kind_e             kind_i,
  input  logic [1:0]        nargs_i,
  input  logic [DATA_W-1:0] a0_i,
  input  logic [DATA_W-1:0] a1_i,
  output logic [DATA_W-1:0] result_o,
  output status_e           status_o
);

  logic              is_stmt;
  logic              arity_ok;
  logic [DATA_W-1:0] value;

  // Reserved context behaves as a statement call.
  assign is_stmt  = (kind_i == KIND_STMT) || (kind_i == KIND_RSVD);
  assign arity_ok = (nargs_i == ARITY[fid_i]);

  // Raw routine value, before any error or discard masking.
  always_comb begin
    value = '0;
    case (fid_i)
      FID_SUM:     value = a0_i + a1_i;
      // 4-bit wrap: only a0[2:0] survive the shift into a nibble.
      FID_DOUBLE:  value = DATA_W'({a0_i[2:0], 1'b0});
      FID_NO_ARGS: value = DATA_W'(1);
      FID_TASK1:   value = a0_i << 1;
      default:     value = '0;
    endcase
  end

  // Arity error dominates; context only judged on a well-formed call.
  always_comb begin
    result_o = '0;
    status_o = ST_OK;
    if (!arity_ok) begin
      status_o = ST_ERR_ARITY;
    end else if (is_task(fid_i)) begin
      if (!is_stmt) status_o = ST_ERR_CTX;
      else          result_o = value;
    end else begin
      if (is_stmt)                       status_o = ST_ERR_CTX;
      else if (kind_i == KIND_EXPR)      result_o = value;
    end
  end

endmodule

// File: rtl/tf_call_responder.sv
// Callee-side call responder: accepts a call request, collects its
// argument beats, executes the routine and returns one response beat.
//   clk, rst                       : clock, synchronous active-high reset
//   req_valid/req_ready            : call request handshake
//   req_fid, req_kind, req_nargs   : routine, context, argument count
//   arg_valid/arg_ready, arg_data  : argument beats
//   rsp_valid/rsp_ready            : response handshake
//   rsp_data, rsp_status           : result and status
module tf_call_responder
  import tf_call_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_fid,
  input  logic [1:0]        req_kind,
  input  logic [1:0]        req_nargs,
  input  logic              arg_valid,
  output logic              arg_ready,
  input  logic [DATA_W-1:0] arg_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_status
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARGS = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]        state_q,      state_d;
  fid_e              fid_q,        fid_d;
  kind_e             kind_q,       kind_d;
  logic [1:0]        nargs_q,      nargs_d;
  logic [1:0]        cnt_q,        cnt_d;
  logic [DATA_W-1:0] a0_q,         a0_d;
  logic [DATA_W-1:0] a1_q,         a1_d;
  logic [DATA_W-1:0] rsp_data_q,   rsp_data_d;
  logic [1:0]        rsp_status_q, rsp_status_d;

  logic [DATA_W-1:0] exec_result;
  status_e           exec_status;

  tf_call_exec #(.DATA_W(DATA_W)) u_exec (
    .fid_i    (fid_q),
    .kind_i   (kind_q),
    .nargs_i  (nargs_q),
    .a0_i     (a0_q),
    .a1_i     (a1_q),
    .result_o (exec_result),
    .status_o (exec_status)
  );

  // Handshake strobes decode from state only; rst gating keeps them quiet
  // during the reset cycle.
  assign req_ready  = !rst && (state_q == S_IDLE);
  assign arg_ready  = !rst && (state_q == S_ARGS);
  assign rsp_valid  = !rst && (state_q == S_RESP);
  assign rsp_data   = rsp_data_q;
  assign rsp_status = rsp_status_q;

  // Next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    fid_d        = fid_q;
    kind_d       = kind_q;
    nargs_d      = nargs_q;
    cnt_d        = cnt_q;
    a0_d         = a0_q;
    a1_d         = a1_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          fid_d   = fid_e'(req_fid);
          kind_d  = kind_e'(req_kind);
          nargs_d = req_nargs;
          cnt_d   = 2'd0;
          a0_d    = '0;
          a1_d    = '0;
          state_d = (req_nargs != 2'd0) ? S_ARGS : S_EXEC;
        end
      end
      S_ARGS: begin
        if (arg_valid) begin
          // A third beat is accepted but has no slot.
          if (cnt_q == 2'd0)      a0_d = arg_data;
          else if (cnt_q == 2'd1) a1_d = arg_data;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == nargs_q - 2'd1) state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        rsp_data_d   = exec_result;
        rsp_status_d = 2'(exec_status);
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      fid_q        <= FID_SUM;
      kind_q       <= KIND_EXPR;
      nargs_q      <= 2'd0;
      cnt_q        <= 2'd0;
      a0_q         <= '0;
      a1_q         <= '0;
      rsp_data_q   <= '0;
      rsp_status_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      fid_q        <= fid_d;
      kind_q       <= kind_d;
      nargs_q      <= nargs_d;
      cnt_q        <= cnt_d;
      a0_q         <= a0_d;
      a1_q         <= a1_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
    end
  end

endmodule

// File: doc/tf_call_responder.md
# tf_call_responder

Callee-side engine for a hardware task/function call channel: accepts a call request naming one of four routines, receives its argument beats, and checks arity and call context. It then executes the routine and returns a single response beat carrying the result or an error status. It sits behind any initiator that issues calls as expressions, statements or void-casts, and mirrors the language rules for function vs. task calls.

## Interface
- DATA_W, 8: argument/result width (min 4).
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  call request present.
- req_ready  out  1  responder idle, can accept request.
- req_fid  in  2  routine: 0 SUM, 1 DOUBLE, 2 NO_ARGS, 3 TASK1.
- req_kind  in  2  call context: 0 EXPR, 1 STMT, 2 VOID_CAST, 3 reserved (treated as STMT).
- req_nargs  in  2  number of argument beats that follow (0..3).
- arg_valid  in  1  argument beat present.
- arg_ready  out  1  responder accepts argument beat.
- arg_data  in  DATA_W  argument value.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  initiator accepts response.
- rsp_data  out  DATA_W  result (0 on any error or discard).
- rsp_status  out  2  0 OK, 1 ERR_ARITY, 2 ERR_CTX.

## Operation
- FSM states: IDLE, ARGS, EXEC, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch fid/kind/nargs, clear arg counter, go to ARGS if nargs>0, else go to EXEC.
- ARGS: arg_ready=1. Each arg handshake stores arg_data into slot[count] when count<2; the third beat is consumed and discarded. Count increments. On handshake of beat nargs, go to EXEC.
- EXEC (one cycle): compute result and status, register them into rsp_data/rsp_status, go to RESP.
- RESP: rsp_valid=1, outputs stable until rsp_ready. On handshake go to IDLE.
- Arity: SUM=2, DOUBLE=1, NO_ARGS=0, TASK1=1. A mismatch gives ERR_ARITY. The initiator's declared beats are still all consumed.
- Context check (only when arity OK):
  - Functions (fid 0-2) with STMT give ERR_CTX.
  - TASK1 with EXPR or VOID_CAST gives ERR_CTX.
  - A function with VOID_CAST gives OK with rsp_data=0 (result discarded).
- Precedence: ERR_ARITY over ERR_CTX.
- Results:
  - SUM = (a0+a1) mod 2^DATA_W, carry dropped.
  - DOUBLE = ({a0[3:0],1'b0}) mod 16, zero-extended to DATA_W.
  - NO_ARGS = 1.
  - TASK1 output = (a0<<1) mod 2^DATA_W.

## Timing
- Reset values: state IDLE, rsp_valid=0, rsp_data=0, rsp_status=0, arg_ready=0.
- req_ready=0 while rst is high.
- req_ready and arg_ready are decoded combinationally from state (gated by rst). They have no combinational path from any valid input.
- Latency: if the last arg (or a zero-arg request) handshakes at cycle t, rsp_valid rises at t+2.
- Single outstanding call; no new request is accepted until the response handshakes.
- Backpressure: one arg beat per cycle max. Gaps in arg_valid simply stall in ARGS. rsp_ready held low holds RESP indefinitely.
- Reset mid-call (any state): the next cycle is IDLE with all outputs at their reset values. The partial call is dropped and no response is issued.

## Structure
- Package tf_call_pkg holds:
  - fid_e, kind_e and status_e enums;
  - ARITY constant array indexed by fid;
  - is_task(fid) function.
- Sub-module tf_call_exec: combinational executor taking fid, kind, nargs, a0, a1 and producing result and status. The FSM registers its outputs in EXEC.

## Test plan
- SUM, EXPR, nargs=2, args 8'd1, 8'd2 -> rsp_status OK, rsp_data 3, rsp_valid at t+2 after the last arg.
- SUM, EXPR, nargs=1, arg 1 -> one beat consumed, ERR_ARITY, rsp_data 0.
- SUM, EXPR, nargs=3, args 1,2,3 -> all three beats consumed, ERR_ARITY.
- DOUBLE, arg 8'h0B -> rsp_data 8'h06 (4-bit wrap).
- NO_ARGS as STMT -> ERR_CTX.
- NO_ARGS as VOID_CAST -> OK, data 0.
- NO_ARGS as EXPR -> OK, data 1, rsp_valid two cycles after the request handshake.
- TASK1, STMT, arg 8'h81 -> OK, data 8'h02. Then hold rsp_ready low 5 cycles -> outputs stable and req_ready=0. Then assert rst while in ARGS on a new call -> IDLE next cycle, and no response appears.
